// File: rtl/lpc_io_target.sv
// lpc_io_target: LPC I/O target turning host I/O read/write cycles into register-file strobes.
// Optional LPC_LONG_WAIT_EN inserts NUM_WAIT long-wait SYNC nibbles (4'h6) before the ready SYNC.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int unsigned NUM_WAIT  = 2
) (
    input  logic       PciReset,
    input  logic       LpcClock,
    input  logic       LFRAME_n,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    input  logic [7:0] RdData,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic       Rd,
    output logic [7:0] DataWr
);
`ifdef LPC_LONG_WAIT_EN
    localparam logic [7:0] NW = 8'(NUM_WAIT);
`else
    localparam logic [7:0] NW = 8'(NUM_WAIT * 0);
`endif
    typedef enum logic [3:0] {
        IDLE, CYCTYPE, ADDR, WDATA_L, WDATA_H, HTAR1, HTAR2,
        WAIT, SYNC, RDATA_L, RDATA_H, TTAR1, TTAR2
    } state_t;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        dir_q, dir_d;
    logic [11:0] ioaddr_q, ioaddr_d;
    logic [3:0]  lsn_q, lsn_d;
    logic [7:0]  rdat_q, rdat_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dwr_q, dwr_d;
    logic        wr_q, wr_d, rd_q, rd_d, oe_q, oe_d;
    logic [3:0]  lad_q, lad_d;
    logic        start, hit;
    assign start   = !LFRAME_n && LAD_in == 4'h0;
    // ioaddr_q holds the top three nibbles while the fourth is on the bus
    assign hit     = ioaddr_q[11:1] == BASE_ADDR[15:5];
    assign LAD_out = lad_q;
    assign LAD_oe  = oe_q;
    assign Addr    = addr_q;
    assign Wr      = wr_q;
    assign Rd      = rd_q;
    assign DataWr  = dwr_q;
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            dir_q    <= 1'b0;
            ioaddr_q <= '0;
            lsn_q    <= '0;
            rdat_q   <= '0;
            addr_q   <= '0;
            dwr_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            oe_q     <= 1'b0;
            lad_q    <= 4'hF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            dir_q    <= dir_d;
            ioaddr_q <= ioaddr_d;
            lsn_q    <= lsn_d;
            rdat_q   <= rdat_d;
            addr_q   <= addr_d;
            dwr_q    <= dwr_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            oe_q     <= oe_d;
            lad_q    <= lad_d;
        end
    end
    // Any LFRAME_n low aborts; it restarts only when LAD carries START
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        if (!LFRAME_n) state_d = start ? CYCTYPE : IDLE;
        else begin
            case (state_q)
                CYCTYPE: begin
                    state_d = LAD_in[3:2] == 2'b00 ? ADDR : IDLE;
                    cnt_d   = '0;
                end
                ADDR: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = !hit ? IDLE : dir_q ? WDATA_L : HTAR1;
                end
                WDATA_L: state_d = WDATA_H;
                WDATA_H: state_d = HTAR1;
                HTAR1:   state_d = HTAR2;
                HTAR2: begin
                    state_d = NW != 8'd0 ? WAIT : SYNC;
                    wcnt_d  = '0;
                end
                WAIT: begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (wcnt_q == NW - 8'd1) state_d = SYNC;
                end
                SYNC:    state_d = dir_q ? TTAR1 : RDATA_L;
                RDATA_L: state_d = RDATA_H;
                RDATA_H: state_d = TTAR1;
                TTAR1:   state_d = TTAR2;
                TTAR2:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    // Outputs are decoded from the next state so they appear registered in their own phase
    always_comb begin
        dir_d    = state_q == CYCTYPE ? LAD_in[1] : dir_q;
        ioaddr_d = state_q == ADDR ? {ioaddr_q[7:0], LAD_in} : ioaddr_q;
        addr_d   = state_q == ADDR && (state_d == WDATA_L || state_d == HTAR1)
                   ? {3'b000, ioaddr_q[0], LAD_in} : addr_q;
        lsn_d    = state_q == WDATA_L ? LAD_in : lsn_q;
        dwr_d    = state_q == WDATA_H && state_d == HTAR1 ? {LAD_in, lsn_q} : dwr_q;
        rdat_d   = state_d == SYNC && !dir_q && state_q != SYNC ? RdData : rdat_q;
        wr_d     = state_d == SYNC && dir_q && state_q != SYNC;
        rd_d     = state_d == HTAR1 && !dir_q && state_q == ADDR;
        oe_d     = state_d inside {WAIT, SYNC, RDATA_L, RDATA_H, TTAR1};
        lad_d    = state_d == WAIT ? 4'h6 :
                   state_d == SYNC ? 4'h0 :
                   state_d == RDATA_L ? rdat_q[3:0] :
                   state_d == RDATA_H ? rdat_q[7:4] : 4'hF;
    end
endmodule

// File: tb/tb_lpc_io_target.sv
// tb_lpc_io_target: randomized LPC I/O cycles checked against a phase-numbered reference model.
module tb_lpc_io_target;
    localparam logic [15:0] BASE = 16'h0800;
`ifdef LPC_LONG_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif
    localparam int LAST = 13 + W;
    logic       clk = 1'b0, rst_n = 1'b0, frame_n = 1'b1;
    logic [3:0] lad_i = 4'hF, lad_o;
    logic       oe, wr, rd;
    logic [7:0] addr, dwr, rd_data;
    logic [7:0] regs [32];
    logic [7:0] exp_addr = 8'h00, exp_dwr = 8'h00;
    int         checks = 0, passed = 0;

    assign rd_data = regs[addr[4:0]];
    always #15 clk = ~clk;

    lpc_io_target #(.BASE_ADDR(BASE), .NUM_WAIT(2)) dut (
        .PciReset(rst_n), .LpcClock(clk), .LFRAME_n(frame_n), .LAD_in(lad_i),
        .LAD_out(lad_o), .LAD_oe(oe), .RdData(rd_data), .Addr(addr),
        .Wr(wr), .Rd(rd), .DataWr(dwr)
    );

    // Drives phases 0..stop_at-1 of one host cycle; junk adds a non-START LFRAME_n abort at stop_at.
    task automatic run_tx(input logic [3:0] ct, input logic [15:0] a, input logic [7:0] d,
                          input int stop_at, input bit junk, input string name);
        logic [3:0] bus [LAST];
        logic [7:0] rv;
        bit ok, is_wr;
        ok    = ct[3:2] == 2'b00 && a[15:5] == BASE[15:5];
        is_wr = ct[1];
        rv    = regs[a[4:0]];
        for (int i = 0; i < LAST; i++) bus[i] = 4'hF;
        bus[0] = 4'h0; bus[1] = ct;
        bus[2] = a[15:12]; bus[3] = a[11:8]; bus[4] = a[7:4]; bus[5] = a[3:0];
        if (is_wr) begin bus[6] = d[3:0]; bus[7] = d[7:4]; end
        for (int q = 0; q < stop_at && q < LAST; q++) begin
            int p;
            logic eoe, ewr, erd;
            logic [3:0] elad;
            frame_n = q != 0;
            lad_i   = bus[q];
            @(posedge clk); #1;
            p = q + 1; eoe = 0; ewr = 0; erd = 0; elad = 4'hF;
            if (ok && is_wr) begin
                ewr  = p == 10 + W;
                eoe  = p >= 10 && p <= 11 + W;
                elad = p < 10 + W ? 4'h6 : p == 10 + W ? 4'h0 : 4'hF;
            end
            if (ok && !is_wr) begin
                erd  = p == 6;
                eoe  = p >= 8 && p <= 11 + W;
                elad = p < 8 + W ? 4'h6 : p == 8 + W ? 4'h0 : p == 9 + W ? rv[3:0] :
                       p == 10 + W ? rv[7:4] : 4'hF;
            end
            checks++;
            if (oe !== eoe) $display("FAIL %s oe phase %0d: got %b want %b", name, p, oe, eoe);
            else passed++;
            checks++;
            if (wr !== ewr) $display("FAIL %s wr phase %0d: got %b want %b", name, p, wr, ewr);
            else passed++;
            checks++;
            if (rd !== erd) $display("FAIL %s rd phase %0d: got %b want %b", name, p, rd, erd);
            else passed++;
            if (eoe) begin
                checks++;
                if (lad_o !== elad) $display("FAIL %s lad phase %0d: got %h want %h", name, p, lad_o, elad);
                else passed++;
            end
        end
        if (junk) begin
            frame_n = 1'b0; lad_i = 4'hF;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                frame_n = 1'b1;
                checks++;
                if (oe !== 1'b0 || wr !== 1'b0 || rd !== 1'b0)
                    $display("FAIL %s after abort: got oe%b wr%b rd%b want 000", name, oe, wr, rd);
                else passed++;
            end
        end
        frame_n = 1'b1; lad_i = 4'hF;
        if (ok && stop_at > 5) exp_addr = {3'b000, a[4:0]};
        if (ok && is_wr && stop_at > 7) exp_dwr = d;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({oe, lad_o, wr, rd} !== {1'b0, 4'hF, 1'b0, 1'b0})
            $display("FAIL reset pins: got oe%b lad%h wr%b rd%b want oe0 ladF wr0 rd0", oe, lad_o, wr, rd);
        else passed++;
        checks++;
        if (addr !== 8'h00 || dwr !== 8'h00) $display("FAIL reset regs: got %h/%h want 00/00", addr, dwr);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_basic();
        run_tx(4'h2, 16'h0801, 8'h3C, LAST, 0, "write_0801");
        checks++;
        if (addr !== 8'h01 || dwr !== 8'h3C) $display("FAIL write_0801 regs: got %h/%h want 01/3c", addr, dwr);
        else passed++;
    endtask

    task automatic test_read_basic();
        regs[31] = 8'hA5;
        run_tx(4'h0, 16'h081F, 8'h00, LAST, 0, "read_081F");
        checks++;
        if (addr !== 8'h1F) $display("FAIL read_081F addr: got %h want 1f", addr);
        else passed++;
        regs[2] = 8'h5A;
        run_tx(4'h1, 16'h0802, 8'h00, LAST, 0, "read_0802");
    endtask

    task automatic test_miss();
        run_tx(4'h2, 16'h0820, 8'h11, LAST, 0, "miss_0820");
        run_tx(4'h3, 16'h0900, 8'h22, LAST, 0, "miss_0900");
        checks++;
        if (addr !== exp_addr || dwr !== exp_dwr)
            $display("FAIL miss regs: got %h/%h want %h/%h", addr, dwr, exp_addr, exp_dwr);
        else passed++;
    endtask

    task automatic test_abort_restart();
        run_tx(4'h2, 16'h0807, 8'h99, 4, 0, "abort_first");
        run_tx(4'h2, 16'h0804, 8'h12, LAST, 0, "restart_0804");
        checks++;
        if (addr !== 8'h04 || dwr !== 8'h12) $display("FAIL restart regs: got %h/%h want 04/12", addr, dwr);
        else passed++;
        run_tx(4'h2, 16'h0810, 8'h77, 7, 1, "junk_abort_wr");
        checks++;
        if (addr !== exp_addr || dwr !== exp_dwr)
            $display("FAIL junk_abort regs: got %h/%h want %h/%h", addr, dwr, exp_addr, exp_dwr);
        else passed++;
        run_tx(4'h0, 16'h0803, 8'h00, 9 + W, 1, "junk_abort_rd");
    endtask

    task automatic test_memread_back_to_back();
        run_tx(4'h4, 16'h0805, 8'h00, LAST, 0, "mem_read");
        run_tx(4'h0, 16'h0803, 8'h00, LAST, 0, "read_after_mem");
        checks++;
        if (addr !== 8'h03) $display("FAIL read_after_mem addr: got %h want 03", addr);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [3:0]  ct;
            logic [15:0] a;
            ct = {1'b0, $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom)};
            a  = $urandom_range(0, 3) != 0 ? {BASE[15:5], 5'($urandom)} : 16'($urandom);
            run_tx(ct, a, 8'($urandom), LAST, 0, "random");
            checks++;
            if (addr !== exp_addr || dwr !== exp_dwr)
                $display("FAIL random regs %0d: got %h/%h want %h/%h", n, addr, dwr, exp_addr, exp_dwr);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        run_tx(4'h0, 16'h0802, 8'h00, 8 + W, 0, "read_to_sync");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({oe, lad_o, wr, rd} !== {1'b0, 4'hF, 1'b0, 1'b0})
            $display("FAIL reset_mid pins: got oe%b lad%h wr%b rd%b want oe0 ladF wr0 rd0", oe, lad_o, wr, rd);
        else passed++;
        checks++;
        if (addr !== 8'h00 || dwr !== 8'h00) $display("FAIL reset_mid regs: got %h/%h want 00/00", addr, dwr);
        else passed++;
        exp_addr = 8'h00; exp_dwr = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_tx(4'h2, 16'h080A, 8'hC3, LAST, 0, "write_after_reset");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 8'($urandom);
        test_reset();
        test_write_basic();
        test_read_basic();
        test_miss();
        test_abort_restart();
        test_memread_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
